anel_johnson_n: RTL and testbench

ANEL_JOHNSON_N -- requirements
Module: anel_johnson_n

---
 rtl/anel_pkg.sv | 26 ++
 rtl/anel_johnson_n_if.sv | 35 +++
 rtl/anel_legal_chk.sv | 34 +++
 rtl/anel_johnson_n.sv | 93 +++++++++
 tb/tb_anel_johnson_n.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/anel_pkg.sv
// -----------------------------------------------------------------------------
// anel_pkg
// Shared definitions for the ring / Johnson shift counter:
//   - mode and direction encodings
//   - reset pattern helper (0..01, legal in both ring and Johnson mode)
// -----------------------------------------------------------------------------
package anel_pkg;

   localparam int MAX_W = 32;

   typedef enum logic {
      MODE_RING    = 1'b0,
      MODE_JOHNSON = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   // Only bit 0 set; callers size-cast this down to their own width.
   function automatic logic [MAX_W-1:0] reset_pattern();
      return MAX_W'(1);
   endfunction

endpackage

// File: rtl/anel_johnson_n_if.sv
// -----------------------------------------------------------------------------
// anel_johnson_n_if
// Control / data bundle of the ring / Johnson counter.
//   en        step enable
//   mode      0 = ring (one-hot), 1 = Johnson (twisted ring)
//   dir       0 = left (bit i -> i+1), 1 = right (bit i+1 -> i)
//   load      synchronous parallel load strobe
//   load_data value written to q on load
//   q         registered counter state
//   wrap      one-cycle pulse, sequence completed
//   err       one-cycle pulse, illegal state corrected
// master = driver of the controls, slave = the counter.
// -----------------------------------------------------------------------------
interface anel_johnson_n_if #(
   parameter int WIDTH = 6
);
   logic             en;
   logic             mode;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] q;
   logic             wrap;
   logic             err;

   modport master (
      output en, mode, dir, load, load_data,
      input  q, wrap, err
   );

   modport slave (
      input  en, mode, dir, load, load_data,
      output q, wrap, err
   );
endinterface

// File: rtl/anel_legal_chk.sv
// -----------------------------------------------------------------------------
// anel_legal_chk
// Combinational legality check of a counter state.
//   q          state under test (WIDTH bits)
//   ring_ok    exactly one bit set
//   johnson_ok at most one adjacent bit pair differs (2*WIDTH legal states)
// -----------------------------------------------------------------------------
module anel_legal_chk
   import anel_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] q,
   output logic             ring_ok,
   output logic             johnson_ok
);
   // 6 bits hold counts up to 32 (largest legal WIDTH).
   logic [5:0] ones;
   logic [5:0] edges;

   always_comb begin
      ones  = 6'd0;
      edges = 6'd0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + 6'(q[i]);
      end
      for (int i = 0; i < WIDTH - 1; i++) begin
         edges = edges + 6'(q[i] ^ q[i+1]);
      end
      ring_ok    = (ones == 6'd1);
      johnson_ok = (edges <= 6'd1);
   end

endmodule

// File: rtl/anel_johnson_n.sv
// -----------------------------------------------------------------------------
// anel_johnson_n
// Ring (one-hot) / Johnson (twisted ring) shift counter, WIDTH stages (2..32).
//   clk    single clock, rising edge
//   clear  synchronous active-high reset, q -> 0..01
//   bus    anel_johnson_n_if.slave: en, mode, dir, load, load_data in;
//          q, wrap, err out (all registered)
// Per-edge priority: clear > load > en > hold. An enabled step from a state
// illegal in the current mode re-seeds the counter instead of shifting.
// -----------------------------------------------------------------------------
module anel_johnson_n
   import anel_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input logic              clk,
   input logic              clear,
   anel_johnson_n_if.slave  bus
);
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(reset_pattern());
   localparam logic [WIDTH-1:0] MSB_Q = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] q_r;
   logic             wrap_r;
   logic             err_r;

   logic             ring_ok;
   logic             johnson_ok;
   logic             legal;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] reseed;
   logic             step_wrap;

   anel_legal_chk #(.WIDTH(WIDTH)) u_chk (
      .q          (q_r),
      .ring_ok    (ring_ok),
      .johnson_ok (johnson_ok)
   );

   // Next-state candidates for an enabled step, using the live mode/dir.
   always_comb begin
      legal     = 1'b0;
      shifted   = q_r;
      reseed    = RST_Q;
      step_wrap = 1'b0;
      if (bus.mode == MODE_JOHNSON) begin
         legal   = johnson_ok;
         reseed  = '0;
         shifted = (bus.dir == DIR_LEFT) ? {q_r[WIDTH-2:0], ~q_r[WIDTH-1]}
                                         : {~q_r[0], q_r[WIDTH-1:1]};
         // Johnson period restarts at all-zeros in either direction.
         step_wrap = (shifted == '0);
      end else begin
         legal   = ring_ok;
         reseed  = RST_Q;
         shifted = (bus.dir == DIR_LEFT) ? {q_r[WIDTH-2:0], q_r[WIDTH-1]}
                                         : {q_r[0], q_r[WIDTH-1:1]};
         // Ring period restarts at the direction's entry bit.
         step_wrap = (bus.dir == DIR_LEFT) ? (shifted == RST_Q)
                                           : (shifted == MSB_Q);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         q_r    <= RST_Q;
         wrap_r <= 1'b0;
         err_r  <= 1'b0;
      end else if (bus.load) begin
         q_r    <= bus.load_data;
         wrap_r <= 1'b0;
         err_r  <= 1'b0;
      end else if (bus.en) begin
         if (legal) begin
            q_r    <= shifted;
            wrap_r <= step_wrap;
            err_r  <= 1'b0;
         end else begin
            q_r    <= reseed;
            wrap_r <= 1'b0;
            err_r  <= 1'b1;
         end
      end else begin
         wrap_r <= 1'b0;
         err_r  <= 1'b0;
      end
   end

   assign bus.q    = q_r;
   assign bus.wrap = wrap_r;
   assign bus.err  = err_r;

endmodule

// File: tb/tb_anel_johnson_n.sv
// -----------------------------------------------------------------------------
// tb_anel_johnson_n
// Directed bench for anel_johnson_n at WIDTH = 6.
// -----------------------------------------------------------------------------
module tb_anel_johnson_n;

   localparam int W = 6;

   logic clk = 1'b0;
   logic clear;
   int   checks = 0;
   int   errors = 0;

   anel_johnson_n_if #(.WIDTH(W)) bus ();

   anel_johnson_n #(.WIDTH(W)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      bus.load = 1'b0;
      bus.en   = 1'b0;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      clear         = 1'b1;
      bus.en        = 1'b1;
      bus.load      = 1'b0;
      bus.mode      = 1'b1;
      bus.dir       = 1'b1;
      bus.load_data = 6'b101010;
      tick();
      checks++;
      if (bus.q !== 6'b000001 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset: q=%b wrap=%b err=%b, expected q=000001 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      clear  = 1'b0;
      bus.en = 1'b0;
   endtask

   task automatic test_ring_left();
      logic [W-1:0] exp_q [6] = '{6'b000010, 6'b000100, 6'b001000,
                                  6'b010000, 6'b100000, 6'b000001};
      do_clear();
      bus.mode = 1'b0;
      bus.dir  = 1'b0;
      bus.en   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (bus.q !== exp_q[i] || bus.wrap !== (i == 5) || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL ring_left step %0d: q=%b wrap=%b err=%b, expected q=%b wrap=%b err=0",
                     i, bus.q, bus.wrap, bus.err, exp_q[i], (i == 5));
         end
      end
      bus.en = 1'b0;
   endtask

   task automatic test_johnson_left();
      logic [W-1:0] exp_q [12] = '{6'b000011, 6'b000111, 6'b001111, 6'b011111,
                                   6'b111111, 6'b111110, 6'b111100, 6'b111000,
                                   6'b110000, 6'b100000, 6'b000000, 6'b000001};
      do_clear();
      bus.mode = 1'b1;
      bus.dir  = 1'b0;
      bus.en   = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (bus.q !== exp_q[i] || bus.wrap !== (i == 10) || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL johnson_left step %0d: q=%b wrap=%b err=%b, expected q=%b wrap=%b err=0",
                     i, bus.q, bus.wrap, bus.err, exp_q[i], (i == 10));
         end
      end
      bus.en = 1'b0;
   endtask

   task automatic test_right_dirs();
      logic [W-1:0] ring_q [2] = '{6'b100000, 6'b010000};
      logic [W-1:0] john_q [3] = '{6'b000000, 6'b100000, 6'b110000};
      do_clear();
      bus.mode = 1'b0;
      bus.dir  = 1'b1;
      bus.en   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bus.q !== ring_q[i] || bus.wrap !== (i == 0) || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL ring_right step %0d: q=%b wrap=%b err=%b, expected q=%b wrap=%b err=0",
                     i, bus.q, bus.wrap, bus.err, ring_q[i], (i == 0));
         end
      end
      do_clear();
      bus.mode = 1'b1;
      bus.dir  = 1'b1;
      bus.en   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.q !== john_q[i] || bus.wrap !== (i == 0) || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL johnson_right step %0d: q=%b wrap=%b err=%b, expected q=%b wrap=%b err=0",
                     i, bus.q, bus.wrap, bus.err, john_q[i], (i == 0));
         end
      end
      bus.en = 1'b0;
   endtask

   task automatic test_illegal_load();
      do_clear();
      bus.mode      = 1'b0;
      bus.dir       = 1'b0;
      bus.load      = 1'b1;
      bus.load_data = 6'b000101;
      tick();
      checks++;
      if (bus.q !== 6'b000101 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_load load: q=%b wrap=%b err=%b, expected q=000101 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      bus.load = 1'b0;
      bus.en   = 1'b1;
      tick();
      checks++;
      if (bus.q !== 6'b000001 || bus.wrap !== 1'b0 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_load fix: q=%b wrap=%b err=%b, expected q=000001 wrap=0 err=1",
                  bus.q, bus.wrap, bus.err);
      end
      tick();
      checks++;
      if (bus.q !== 6'b000010 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_load step: q=%b wrap=%b err=%b, expected q=000010 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      bus.en = 1'b0;
   endtask

   task automatic test_clear_priority();
      clear         = 1'b1;
      bus.load      = 1'b1;
      bus.en        = 1'b1;
      bus.mode      = 1'b0;
      bus.load_data = 6'b110000;
      tick();
      checks++;
      if (bus.q !== 6'b000001 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL clear_priority clear: q=%b wrap=%b err=%b, expected q=000001 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      clear = 1'b0;
      tick();
      checks++;
      if (bus.q !== 6'b110000 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL clear_priority load: q=%b wrap=%b err=%b, expected q=110000 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      bus.load = 1'b0;
      bus.en   = 1'b0;
   endtask

   task automatic test_dir_change_hold();
      do_clear();
      bus.mode = 1'b0;
      bus.dir  = 1'b0;
      bus.en   = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.q !== 6'b000100) begin
         errors++;
         $display("FAIL dir_change setup: q=%b, expected q=000100", bus.q);
      end
      bus.dir = 1'b1;
      tick();
      checks++;
      if (bus.q !== 6'b000010 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL dir_change step: q=%b wrap=%b err=%b, expected q=000010 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.q !== 6'b000010 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL hold %0d: q=%b wrap=%b err=%b, expected q=000010 wrap=0 err=0",
                     i, bus.q, bus.wrap, bus.err);
         end
      end
   endtask

   task automatic test_mode_switch_clear();
      do_clear();
      bus.mode = 1'b1;
      bus.dir  = 1'b0;
      bus.en   = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.q !== 6'b000111) begin
         errors++;
         $display("FAIL mode_switch setup: q=%b, expected q=000111", bus.q);
      end
      bus.mode = 1'b0;
      tick();
      checks++;
      if (bus.q !== 6'b000001 || bus.wrap !== 1'b0 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL mode_switch fix: q=%b wrap=%b err=%b, expected q=000001 wrap=0 err=1",
                  bus.q, bus.wrap, bus.err);
      end
      // Clear while the err pulse is showing and another step is requested.
      clear = 1'b1;
      tick();
      checks++;
      if (bus.q !== 6'b000001 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL mode_switch clear: q=%b wrap=%b err=%b, expected q=000001 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      clear = 1'b0;
      // Clear on the edge that would otherwise wrap (ring left from 100000).
      bus.en        = 1'b0;
      bus.load      = 1'b1;
      bus.load_data = 6'b100000;
      tick();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      clear    = 1'b1;
      tick();
      checks++;
      if (bus.q !== 6'b000001 || bus.wrap !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_abort: q=%b wrap=%b err=%b, expected q=000001 wrap=0 err=0",
                  bus.q, bus.wrap, bus.err);
      end
      clear  = 1'b0;
      bus.en = 1'b0;
   endtask

   initial begin
      clear         = 1'b1;
      bus.en        = 1'b0;
      bus.mode      = 1'b0;
      bus.dir       = 1'b0;
      bus.load      = 1'b0;
      bus.load_data = '0;
      test_reset();
      test_ring_left();
      test_johnson_left();
      test_right_dirs();
      test_illegal_load();
      test_clear_priority();
      test_dir_change_hold();
      test_mode_switch_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
